// File: rtl/slicer_pkg.sv
// Shared definitions for the slicer calibration controller: state encoding,
// data width, default threshold and a small saturating-increment helper.
package slicer_pkg;

  localparam int DW = 8;
  localparam logic [DW-1:0] DEF_MID = 8'd122;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/sys_edge_sync.sv
// Brings the asynchronous sys input into clk, emits one-cycle edge strobes
// and tracks how long it has been since the last edge.
module sys_edge_sync #(
  parameter int unsigned LOST_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sys,
  output logic en0,
  output logic en1,
  output logic sys_lost,
  output logic lost_rise
);

  localparam int TW = $clog2(LOST_CYCLES + 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(LOST_CYCLES);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic hist_q, hist_d;
  logic en0_q, en0_d;
  logic en1_q, en1_d;
  logic lost_q, lost_d;
  logic rise_q, rise_d;
  logic [TW-1:0] tmr_q, tmr_d;

  always_comb begin
    s1_d   = sys;
    s2_d   = s1_q;
    hist_d = s2_q;
    en0_d  = hist_q & ~s2_q;
    en1_d  = ~hist_q & s2_q;
    tmr_d  = tmr_q;
    lost_d = lost_q;
    rise_d = 1'b0;
    // An edge always beats expiry; the timer parks at its limit once lost.
    if (en0_q | en1_q) begin
      tmr_d  = '0;
      lost_d = 1'b0;
    end else if (tmr_q != TMR_MAX) begin
      tmr_d = tmr_q + 1'b1;
      if (tmr_d == TMR_MAX) begin
        lost_d = 1'b1;
        rise_d = ~lost_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
      en0_q  <= 1'b0;
      en1_q  <= 1'b0;
      lost_q <= 1'b0;
      rise_q <= 1'b0;
      tmr_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
      en0_q  <= en0_d;
      en1_q  <= en1_d;
      lost_q <= lost_d;
      rise_q <= rise_d;
      tmr_q  <= tmr_d;
    end
  end

  assign en0       = en0_q;
  assign en1       = en1_q;
  assign sys_lost  = lost_q;
  assign lost_rise = rise_q;

endmodule

// File: rtl/slicer_cal_ctrl.sv
// Sequencing/calibration controller for the max/min threshold tracker:
// publish window, window qualification, acquire/lock FSM and threshold register.
module slicer_cal_ctrl
  import slicer_pkg::*;
#(
  parameter int unsigned   WIN_CYCLES  = 5_000_000,
  parameter int unsigned   LOST_CYCLES = 1_000_000,
  parameter int unsigned   LOCK_WINS   = 3,
  parameter logic [DW-1:0] MIN_DIFF    = 8'd16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sys,
  input  logic [DW-1:0] up,
  input  logic [DW-1:0] down,
  input  logic [DW-1:0] mid,
  input  logic [DW-1:0] diff,
  output logic          en0,
  output logic          en1,
  output logic          update,
  output logic          tracker_clr,
  output logic [DW-1:0] thr_out,
  output logic          locked,
  output logic          sys_lost,
  output logic [1:0]    state
);

  localparam int CW = $clog2(WIN_CYCLES);
  localparam int GW = $clog2(LOCK_WINS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIN_CYCLES - 1);
  localparam logic [GW-1:0] GC_LOCK  = GW'(LOCK_WINS);

  logic lost_rise;
  logic edge_any;
  logic good;
  logic upd;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          eval_q, eval_d;
  logic [1:0]    edges_q, edges_d;
  logic [GW-1:0] gc_q, gc_d, gc_inc;
  logic          clr_q, clr_d;
  logic [DW-1:0] thr_q, thr_d;

  sys_edge_sync #(
    .LOST_CYCLES(LOST_CYCLES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sys      (sys),
    .en0      (en0),
    .en1      (en1),
    .sys_lost (sys_lost),
    .lost_rise(lost_rise)
  );

  assign edge_any = en0 | en1;

  // Window bookkeeping; eval trails update by one cycle so the tracker's
  // freshly registered values are what gets qualified.
  always_comb begin
    upd     = (cnt_q == CNT_LAST) && !clr_q;
    cnt_d   = (clr_q || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    eval_d  = upd;
    edges_d = edge_any ? sat_inc2(edges_q) : edges_q;
    if (clr_q || eval_q) begin
      edges_d = '0;
    end
    good = (edges_q >= 2'd2) && (up > down) && (diff >= MIN_DIFF);
  end

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    thr_d   = thr_q;
    gc_d    = gc_q;
    gc_inc  = (gc_q >= GC_LOCK) ? gc_q : gc_q + 1'b1;
    if (lost_rise && state_q != ST_IDLE) begin
      state_d = ST_ACQ;
      clr_d   = 1'b1;
      gc_d    = '0;
      thr_d   = DEF_MID;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          clr_d   = 1'b1;
          gc_d    = '0;
          thr_d   = DEF_MID;
        end
        ST_ACQ: begin
          if (eval_q) begin
            if (good) begin
              gc_d = gc_inc;
              if (gc_inc == GC_LOCK) begin
                state_d = ST_LOCK;
                thr_d   = mid;
              end
            end else begin
              gc_d = '0;
            end
          end
        end
        ST_LOCK: begin
          if (eval_q) begin
            if (good) begin
              thr_d = mid;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (eval_q) begin
            if (good) begin
              state_d = ST_LOCK;
              thr_d   = mid;
            end else begin
              state_d = ST_ACQ;
              clr_d   = 1'b1;
              gc_d    = '0;
              thr_d   = DEF_MID;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      eval_q  <= 1'b0;
      edges_q <= '0;
      gc_q    <= '0;
      clr_q   <= 1'b0;
      thr_q   <= DEF_MID;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eval_q  <= eval_d;
      edges_q <= edges_d;
      gc_q    <= gc_d;
      clr_q   <= clr_d;
      thr_q   <= thr_d;
    end
  end

  assign update      = upd;
  assign tracker_clr = clr_q;
  assign thr_out     = thr_q;
  assign locked      = (state_q == ST_LOCK);
  assign state       = state_q;

endmodule

// File: tb/tb_slicer_cal_ctrl.sv
// Bench for slicer_cal_ctrl: scoreboarded sys edge strobes, window timing
// tracking and directed FSM scenarios with a short window.
module tb_slicer_cal_ctrl;

  localparam int WIN  = 100;
  localparam int LOST = 40;
  localparam int S_IDLE = 0;
  localparam int S_ACQ  = 1;
  localparam int S_LOCK = 2;
  localparam int S_HOLD = 3;

  logic       clk;
  logic       rst_n;
  logic       sys;
  logic [7:0] up, down, mid, diff;
  logic       en0, en1, update, tracker_clr, locked, sys_lost;
  logic [7:0] thr_out;
  logic [1:0] state;

  typedef struct {
    int   cyc;
    logic rise;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   total;
  int   bad;
  int   exp_upd;
  bit   upd_armed;
  bit   tog_en;
  int   tog_until;
  int   pulse_at;

  slicer_cal_ctrl #(
    .WIN_CYCLES (WIN),
    .LOST_CYCLES(LOST),
    .LOCK_WINS  (3),
    .MIN_DIFF   (8'd16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sys        (sys),
    .up         (up),
    .down       (down),
    .mid        (mid),
    .diff       (diff),
    .en0        (en0),
    .en1        (en1),
    .update     (update),
    .tracker_clr(tracker_clr),
    .thr_out    (thr_out),
    .locked     (locked),
    .sys_lost   (sys_lost),
    .state      (state)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1);
  end

  // Monitor + sys driver: strobe scoreboard, update timing, periodic toggling.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (en0 || en1) begin
          if (exp_q.size() == 0) begin
            chk("strobe_unexpected", {en1, en0}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("strobe_cyc", cyc, e.cyc);
            chk("strobe_pol", {en1, en0}, e.rise ? 2 : 1);
            $display("strobe en%0d at cyc %0d", e.rise ? 1 : 0, cyc);
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          chk("strobe_missing", 0, e.cyc);
        end
        if (tracker_clr) begin
          exp_upd   = cyc + WIN;
          upd_armed = 1'b1;
          $display("tracker_clr at cyc %0d", cyc);
        end
        if (update) begin
          chk("update_cyc", cyc, upd_armed ? exp_upd : -1);
          $display("update at cyc %0d state=%0d thr=%0d", cyc, state, thr_out);
          exp_upd   = cyc + WIN;
          upd_armed = 1'b1;
        end else if (upd_armed && cyc == exp_upd) begin
          chk("update_missing", 0, 1);
        end
        if ((tog_en && (cyc % 10 == 0) && cyc < tog_until) || cyc == pulse_at) begin
          sys = ~sys;
          exp_q.push_back('{cyc + 3, sys});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_upd();
    int i;
    i = 0;
    @(negedge clk);
    while (!update && i < 3 * WIN) begin
      @(negedge clk);
      i++;
    end
    if (!update) chk("update_timeout", 0, 1);
  endtask

  task automatic after_eval(input string tag, input int st, input int thr, input int clr);
    wait_upd();
    step(2);
    chk({tag, "_state"}, state, st);
    chk({tag, "_thr"}, thr_out, thr);
    chk({tag, "_locked"}, locked, (st == S_LOCK) ? 1 : 0);
    chk({tag, "_clr"}, tracker_clr, clr);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en0"}, en0, 0);
    chk({tag, "_en1"}, en1, 0);
    chk({tag, "_update"}, update, 0);
    chk({tag, "_clr"}, tracker_clr, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_lost"}, sys_lost, 0);
    chk({tag, "_thr"}, thr_out, 122);
    chk({tag, "_state"}, state, S_IDLE);
  endtask

  initial begin
    total = 0; bad = 0; exp_upd = 0; upd_armed = 1'b0;
    tog_en = 1'b0; tog_until = 0; pulse_at = -1;
    sys = 1'b0; rst_n = 1'b0;
    up = 8'd180; down = 8'd60; mid = 8'd120; diff = 8'd120;

    // 1: reset release with sys held low
    step(3);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step(1);
    chk("idle_clr", tracker_clr, 1);
    chk("idle_to_acq", state, S_ACQ);
    chk("idle_thr", thr_out, 122);
    step(1);
    chk("clr_one_cycle", tracker_clr, 0);
    step(37);
    chk("lost_not_yet", sys_lost, 0);
    step(1);
    chk("lost_set", sys_lost, 1);
    step(1);
    chk("lost_clr", tracker_clr, 1);
    chk("lost_state", state, S_ACQ);
    wait_upd();
    wait_upd();

    // 2: toggle sys, three good windows to lock
    tog_until = 1 << 30;
    tog_en    = 1'b1;
    after_eval("acq1", S_ACQ, 122, 0);
    chk("lost_cleared", sys_lost, 0);
    after_eval("acq2", S_ACQ, 122, 0);
    after_eval("lock", S_LOCK, 120, 0);

    // 3: one narrow eye, then a boundary-width good window
    diff = 8'd8; mid = 8'd100;
    after_eval("hold", S_HOLD, 120, 0);
    diff = 8'd16; mid = 8'd124;
    after_eval("relock", S_LOCK, 124, 0);

    // 4: two windows with wrapped diff
    up = 8'd50; down = 8'd60; diff = 8'd246;
    after_eval("hold2", S_HOLD, 124, 0);
    after_eval("drop", S_ACQ, 122, 1);
    up = 8'd180; down = 8'd60; mid = 8'd120; diff = 8'd120;
    after_eval("reacq1", S_ACQ, 122, 0);
    after_eval("reacq2", S_ACQ, 122, 0);
    after_eval("lock2", S_LOCK, 120, 0);

    // 5: last edge placed so the lost expiry coincides with eval
    tog_until = cyc + 55;
    pulse_at  = cyc + 55;
    wait_upd();
    chk("lost_pre_eval", sys_lost, 0);
    step(1);
    chk("lost_on_eval", sys_lost, 1);
    step(1);
    chk("lost_wins_state", state, S_ACQ);
    chk("lost_wins_clr", tracker_clr, 1);
    chk("lost_wins_thr", thr_out, 122);
    pulse_at = cyc + 5;
    step(8);
    chk("lost_held_at_edge", sys_lost, 1);
    step(1);
    chk("lost_cleared_by_edge", sys_lost, 0);
    tog_until = 1 << 30;
    after_eval("reacq3", S_ACQ, 122, 0);
    after_eval("reacq4", S_ACQ, 122, 0);
    after_eval("lock3", S_LOCK, 120, 0);

    // 6: asynchronous reset mid-window while locked
    step(30);
    #2;
    rst_n  = 1'b0;
    tog_en = 1'b0;
    sys    = 1'b0;
    exp_q.delete();
    upd_armed = 1'b0;
    #1;
    chk_reset_vals("arst");
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("restart_clr", tracker_clr, 1);
    chk("restart_state", state, S_ACQ);
    chk("restart_thr", thr_out, 122);
    wait_upd();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
